fault_campaign_ctrl: RTL and testbench
======================================

# fault_campaign_ctrl

Synthesizable controller that runs a golden-vs-faulty stuck-at fault campaign on two instances of a DUT. It draws pseudo-random test vectors and run lengths from an internal LFSR and sweeps every still-undetected fault index through an external injector via a handshake. After each run it compares the golden and faulty output buses and accumulates a detection bitmap. A test's detections are committed only if that test is effective, and the campaign stops on a coverage target or a test limit.

## Interface
- TV_W, 8, test-vector width
- OUT_W, 17, compared output width
- NUM_FAULTS, 1586, fault-list length (indices 1..NUM_FAULTS)
- FIDX_W, 11, fault-index width; must satisfy 2^FIDX_W > NUM_FAULTS
- EF_MIN, 2, minimum new detections for a test to be committed
- UT_LIMIT, 1000, maximum number of tests
- DES_COV, 99, target coverage in percent (integer)
- CC_MOD, 100, run length = lfsr[31:16] % CC_MOD
- SEED, 32'hACE1_0001, LFSR reset value (must be non-zero)

- clk  in  1  campaign and DUT clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse in IDLE begins a campaign
- dut_reset  out  1  active-high reset to both DUT instances
- test_vector  out  TV_W  stimulus to both DUTs
- golden_out  in  OUT_W  golden DUT outputs
- faulty_out  in  OUT_W  faulty DUT outputs
- fault_req  out  1  level; high = inject fault_index
- fault_index  out  FIDX_W  fault to inject; stable while fault_req or fault_ack is high
- fault_ack  in  1  injector acknowledge (four-phase)
- cmp_mask  in  OUT_W  only with FCC_CMP_MASK_EN; 1 = ignore bit
- busy  out  1  campaign running
- done  out  1  high from campaign end until next start
- tests_run  out  16  tests executed
- detected  out  FIDX_W  committed detected-fault count
- cov_met  out  1  coverage target reached

## Operation
- Reset: all outputs are 0 except dut_reset=1. lfsr=SEED. Both bitmaps (ct_map, at_map) are cleared.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances exactly once per NEW_TEST.
- FSM states: IDLE, NEW_TEST, SEL, DRST, INJ, RUN, CMP, REM, COMMIT, CHECK, DONE.
- IDLE: on start, go to NEW_TEST. This clears at_map, detected, tests_run, done and cov_met, and sets busy=1.
- NEW_TEST:
  - Advance the LFSR.
  - Register test_vector = lfsr_next[TV_W-1:0] and cc = lfsr_next[31:16] % CC_MOD.
  - Clear ct_map and ct_cnt.
  - Set idx=1 and increment tests_run.
- SEL: if idx > NUM_FAULTS, go to COMMIT. Otherwise, if at_map[idx] is set, increment idx (one index per cycle); else go to DRST.
- DRST: hold dut_reset=1 for exactly one cycle, then go to INJ.
- INJ: with dut_reset=0, drive fault_req=1 and fault_index=idx. Wait for fault_ack=1, load the run counter with cc, then go to RUN.
- RUN: decrement the run counter each cycle. Go to CMP when it is 0; with cc=0, RUN lasts 1 cycle.
- CMP: diff = golden_out ^ faulty_out (masked if configured). If diff≠0, set ct_map[idx] and increment ct_cnt.
- REM: drop fault_req. Wait for fault_ack=0, increment idx, then go to SEL.
- COMMIT: if ct_cnt ≥ EF_MIN, set at_map |= ct_map and detected += ct_cnt. ct_map only contains faults not already in at_map, so no double counting occurs. Otherwise discard.
- CHECK:
  - cov_met = (detected*100 ≥ DES_COV*NUM_FAULTS), using a 32-bit product.
  - If cov_met or tests_run == UT_LIMIT, go to DONE; else go to NEW_TEST.
- DONE: busy=0, done=1, dut_reset=1. Return to IDLE next cycle; done is held until the next start.
- start outside IDLE is ignored.
- If all faults are already detected, a test sweeps SEL only and commits nothing.

## Timing
- Per undetected fault: 1 (SEL) + 1 (DRST) + injector latency + max(cc,1) + 1 (CMP) + removal latency cycles.
- Compare is sampled in the CMP cycle, i.e. cc+1 edges after fault_ack was seen high.
- test_vector is registered and constant for a whole test.
- fault_index changes only in SEL while fault_req=0 and fault_ack=0.
- Asynchronous reset mid-campaign:
  - Immediately returns to IDLE and asserts dut_reset.
  - Drops fault_req. The injector must release its fault on fault_req=0.
  - All progress is lost.
- No fault_ack timeout; a stuck injector hangs in INJ or REM.

## Configuration
- FCC_CMP_MASK_EN defined: the cmp_mask port exists and diff = (golden_out ^ faulty_out) & ~cmp_mask.
- Not defined: no port exists and all OUT_W bits are compared.

## Test plan
- Equal-output stub (faulty_out=golden_out), UT_LIMIT=3 -> three tests run and detected=0. Then done=1, cov_met=0 and tests_run=3.
- NUM_FAULTS=4, EF_MIN=2, stub flags faults 2 and 4 on the first test -> detected=2 after COMMIT. The second test skips 2 and 4 (no INJ for them).
- Same setup, stub flags only fault 3 -> ct_cnt=1 < EF_MIN, so nothing is committed, detected=0, and fault 3 is retried next test.
- NUM_FAULTS=4, DES_COV=75, stub flags faults 1,2,3 in one test -> cov_met=1 and done after tests_run=1.
- Injector delays fault_ack by 5 cycles and forces cc=0 -> one RUN cycle. fault_index stays stable throughout the handshake, and dut_reset pulses for exactly 1 cycle per fault.
- reset_n low in RUN -> next cycle shows IDLE, fault_req=0 and dut_reset=1. A new start restarts at tests_run=1 with the LFSR at SEED's first successor.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: golden-vs-faulty stuck-at fault campaign sequencer.
// An LFSR draws a test vector and run length per test. Every fault not yet in
// the accumulated map is injected through a four-phase req/ack handshake. The
// golden and faulty outputs are compared after the run. A test's detections
// are committed only when it finds at least EF_MIN new faults.
//
// Optional build macro: FCC_CMP_MASK_EN adds the cmp_mask port (1 = ignore bit).
//
// state    | meaning
// IDLE     | waiting for start, DUTs held in reset
// NEW_TEST | advance LFSR, latch vector and run length, clear per-test map
// SEL      | skip already-detected faults, or leave for COMMIT past the last index
// DRST     | one-cycle DUT reset before the injection
// INJ      | request injection of fault_index, wait for ack
// RUN      | let both DUTs run for max(cc,1) cycles
// CMP      | compare outputs, record a detection
// REM      | drop the request, wait for ack release
// COMMIT   | merge per-test detections if the test was effective
// CHECK    | stop on coverage target or test limit
// DONE     | campaign finished, one cycle

module fault_campaign_ctrl #(
    parameter int unsigned TV_W       = 8,
    parameter int unsigned OUT_W      = 17,
    parameter int unsigned NUM_FAULTS = 1586,
    parameter int unsigned FIDX_W     = 11,
    parameter int unsigned EF_MIN     = 2,
    parameter int unsigned UT_LIMIT   = 1000,
    parameter int unsigned DES_COV    = 99,
    parameter int unsigned CC_MOD     = 100,
    parameter logic [31:0] SEED       = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              dut_reset,
    output logic [TV_W-1:0]   test_vector,
    input  logic [OUT_W-1:0]  golden_out,
    input  logic [OUT_W-1:0]  faulty_out,
`ifdef FCC_CMP_MASK_EN
    input  logic [OUT_W-1:0]  cmp_mask,
`endif
    output logic              fault_req,
    output logic [FIDX_W-1:0] fault_index,
    input  logic              fault_ack,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tests_run,
    output logic [FIDX_W-1:0] detected,
    output logic              cov_met
);

    // idx must reach NUM_FAULTS+1, which may need one bit more than fault_index
    localparam int          IDX_W   = FIDX_W + 1;
    localparam logic [31:0] POLY    = 32'h8020_0003;
    localparam logic [15:0] CC_DIV  = 16'(CC_MOD);
    localparam logic [31:0] COV_TGT = 32'(DES_COV * NUM_FAULTS);

    typedef enum logic [3:0] {
        S_IDLE, S_NEW_TEST, S_SEL, S_DRST, S_INJ, S_RUN,
        S_CMP, S_REM, S_COMMIT, S_CHECK, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           lfsr_q, lfsr_d, lfsr_nxt;
    logic [TV_W-1:0]       tv_q, tv_d;
    logic [15:0]           cc_q, cc_d;
    logic [15:0]           run_cnt_q, run_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_FAULTS-1:0] ct_map_q, ct_map_d;
    logic [NUM_FAULTS-1:0] at_map_q, at_map_d;
    logic [FIDX_W-1:0]     ct_cnt_q, ct_cnt_d;
    logic [FIDX_W-1:0]     detected_q, detected_d;
    logic [15:0]           tests_run_q, tests_run_d;
    logic                  done_q, done_d;
    logic                  cov_met_q, cov_met_d;

    logic [NUM_FAULTS-1:0] idx_onehot;
    logic                  idx_past_end;
    logic                  at_hit;
    logic [OUT_W-1:0]      diff;
    logic [31:0]           cov_prod;
    logic                  cov_now;
    logic                  limit_hit;

`ifdef FCC_CMP_MASK_EN
    assign diff = (golden_out ^ faulty_out) & ~cmp_mask;
`else
    assign diff = golden_out ^ faulty_out;
`endif

    assign lfsr_nxt     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    assign idx_past_end = (idx_q > IDX_W'(NUM_FAULTS));
    assign at_hit       = |(at_map_q & idx_onehot);
    assign cov_prod     = 32'(detected_q) * 32'd100;
    assign cov_now      = (cov_prod >= COV_TGT);
    assign limit_hit    = (tests_run_q == 16'(UT_LIMIT));

    // Decode the current fault index into a bitmap position (index 1 -> bit 0)
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            idx_onehot[i] = (idx_q == IDX_W'(i + 1));
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_NEW_TEST;
            S_NEW_TEST: state_d = S_SEL;
            S_SEL: begin
                if (idx_past_end)  state_d = S_COMMIT;
                else if (!at_hit)  state_d = S_DRST;
            end
            S_DRST:     state_d = S_INJ;
            S_INJ:      if (fault_ack) state_d = S_RUN;
            S_RUN:      if (run_cnt_q <= 16'd1) state_d = S_CMP;
            S_CMP:      state_d = S_REM;
            S_REM:      if (!fault_ack) state_d = S_SEL;
            S_COMMIT:   state_d = S_CHECK;
            S_CHECK:    state_d = (cov_now || limit_hit) ? S_DONE : S_NEW_TEST;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        dut_reset = (state_q == S_IDLE) || (state_q == S_DRST) || (state_q == S_DONE);
        fault_req = (state_q == S_INJ) || (state_q == S_RUN) || (state_q == S_CMP);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    end

    // Datapath next values for each state
    always_comb begin
        lfsr_d      = lfsr_q;
        tv_d        = tv_q;
        cc_d        = cc_q;
        run_cnt_d   = run_cnt_q;
        idx_d       = idx_q;
        ct_map_d    = ct_map_q;
        at_map_d    = at_map_q;
        ct_cnt_d    = ct_cnt_q;
        detected_d  = detected_q;
        tests_run_d = tests_run_q;
        done_d      = done_q;
        cov_met_d   = cov_met_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    at_map_d    = '0;
                    detected_d  = '0;
                    tests_run_d = '0;
                    done_d      = 1'b0;
                    cov_met_d   = 1'b0;
                end
            end
            S_NEW_TEST: begin
                lfsr_d      = lfsr_nxt;
                tv_d        = lfsr_nxt[TV_W-1:0];
                cc_d        = lfsr_nxt[31:16] % CC_DIV;
                ct_map_d    = '0;
                ct_cnt_d    = '0;
                idx_d       = IDX_W'(1);
                tests_run_d = tests_run_q + 16'd1;
            end
            S_SEL: begin
                if (!idx_past_end && at_hit) idx_d = idx_q + IDX_W'(1);
            end
            S_INJ: begin
                if (fault_ack) run_cnt_d = cc_q;
            end
            S_RUN: begin
                if (run_cnt_q != 16'd0) run_cnt_d = run_cnt_q - 16'd1;
            end
            S_CMP: begin
                if (diff != '0) begin
                    ct_map_d = ct_map_q | idx_onehot;
                    ct_cnt_d = ct_cnt_q + FIDX_W'(1);
                end
            end
            S_REM: begin
                if (!fault_ack) idx_d = idx_q + IDX_W'(1);
            end
            S_COMMIT: begin
                // ct_map never overlaps at_map, so the count adds directly
                if (ct_cnt_q >= FIDX_W'(EF_MIN)) begin
                    at_map_d   = at_map_q | ct_map_q;
                    detected_d = detected_q + ct_cnt_q;
                end
            end
            S_CHECK: begin
                cov_met_d = cov_now;
                if (cov_now || limit_hit) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q      <= SEED;
            tv_q        <= '0;
            cc_q        <= '0;
            run_cnt_q   <= '0;
            idx_q       <= '0;
            ct_map_q    <= '0;
            at_map_q    <= '0;
            ct_cnt_q    <= '0;
            detected_q  <= '0;
            tests_run_q <= '0;
            done_q      <= 1'b0;
            cov_met_q   <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            tv_q        <= tv_d;
            cc_q        <= cc_d;
            run_cnt_q   <= run_cnt_d;
            idx_q       <= idx_d;
            ct_map_q    <= ct_map_d;
            at_map_q    <= at_map_d;
            ct_cnt_q    <= ct_cnt_d;
            detected_q  <= detected_d;
            tests_run_q <= tests_run_d;
            done_q      <= done_d;
            cov_met_q   <= cov_met_d;
        end
    end

    assign test_vector = tv_q;
    assign fault_index = idx_q[FIDX_W-1:0];
    assign tests_run   = tests_run_q;
    assign detected    = detected_q;
    assign done        = done_q;
    assign cov_met     = cov_met_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl with a small fault list (4 faults),
// a behavioural injector with programmable ack delay, and a faulty-output stub
// that flips bit 0 for a chosen set of fault indices.
// LFSR successors of SEED 0xACE10001: 0xD6508003, 0xEB084002, 0x75842001
// -> test_vector 03, 02, 01 and cc (mod 9) 0, 3, 6.

module tb_fault_campaign_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        dut_reset;
    logic [7:0]  test_vector;
    logic [16:0] golden_out;
    logic [16:0] faulty_out;
    logic        fault_req;
    logic [2:0]  fault_index;
    logic        fault_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] tests_run;
    logic [2:0]  detected;
    logic        cov_met;

    int tests = 0;
    int fails = 0;

    fault_campaign_ctrl #(
        .TV_W(8), .OUT_W(17), .NUM_FAULTS(4), .FIDX_W(3), .EF_MIN(2),
        .UT_LIMIT(3), .DES_COV(75), .CC_MOD(9), .SEED(32'hACE1_0001)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dut_reset(dut_reset),
        .test_vector(test_vector), .golden_out(golden_out), .faulty_out(faulty_out),
        .fault_req(fault_req), .fault_index(fault_index), .fault_ack(fault_ack),
        .busy(busy), .done(done), .tests_run(tests_run), .detected(detected),
        .cov_met(cov_met)
    );

    always #5 clk = ~clk;

    // Stub DUT pair: faulty differs in bit 0 while a flagged fault is injected
    logic [7:0] flag_set = 8'h00;
    logic       first_only = 1'b0;
    logic       stub_hit;
    assign stub_hit   = fault_req && fault_ack && flag_set[fault_index] &&
                        (!first_only || (tests_run == 16'd1));
    assign golden_out = {9'h0, test_vector};
    assign faulty_out = golden_out ^ {16'h0, stub_hit};

    // Injector: ack rises inj_delay+1 edges after req is seen, drops after req falls
    int inj_delay = 1;
    int inj_cnt = 0;
    always @(posedge clk) begin
        if (!fault_req) begin
            fault_ack <= 1'b0;
            inj_cnt   <= 0;
        end else begin
            if (inj_cnt >= inj_delay) fault_ack <= 1'b1;
            inj_cnt <= inj_cnt + 1;
        end
    end

    // Monitors
    logic       prev_req = 1'b0;
    logic [2:0] prev_idx = 3'd0;
    int         inj_total = 0;
    int         inj_per_idx[8];
    int         both_cnt = 0;
    int         both_log[$];
    int         tv_log[$];
    int         rst_w = 0;
    int         rst_pulses = 0;
    int         rst_max_w = 0;
    int         idx_viol = 0;

    always @(negedge clk) begin
        prev_req <= fault_req;
        prev_idx <= fault_index;
        if (fault_req && !prev_req) begin
            inj_total <= inj_total + 1;
            inj_per_idx[fault_index] <= inj_per_idx[fault_index] + 1;
            tv_log.push_back(int'(test_vector));
        end
        if (prev_req && !fault_req) begin
            both_log.push_back(both_cnt);
            both_cnt <= 0;
        end else if (fault_req && fault_ack) begin
            both_cnt <= both_cnt + 1;
        end
        if (busy && dut_reset) begin
            rst_w <= rst_w + 1;
        end else if (rst_w > 0) begin
            rst_pulses <= rst_pulses + 1;
            if (rst_w > rst_max_w) rst_max_w <= rst_w;
            rst_w <= 0;
        end
        if ((fault_req || fault_ack) && (fault_index != prev_idx)) idx_viol <= idx_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        inj_total  = 0;
        for (int i = 0; i < 8; i++) inj_per_idx[i] = 0;
        both_log.delete();
        tv_log.delete();
        rst_pulses = 0;
        rst_max_w  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    int exp_both[12] = '{3, 3, 3, 3, 5, 5, 5, 5, 8, 8, 8, 8};
    int exp_tv[3]    = '{3, 2, 1};

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 8; i++) inj_per_idx[i] = 0;
        #12;
        chk("rst_dut_reset", 32'(dut_reset), 32'd1);
        chk("rst_fault_req", 32'(fault_req), 32'd0);
        chk("rst_fault_index", 32'(fault_index), 32'd0);
        chk("rst_test_vector", 32'(test_vector), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tests_run", 32'(tests_run), 32'd0);
        chk("rst_detected", 32'(detected), 32'd0);
        chk("rst_cov_met", 32'(cov_met), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // A: equal outputs, slow injector, three tests with cc = 0, 3, 6
        inj_delay = 5;
        flag_set  = 8'h00;
        clear_mon();
        pulse_start();
        chk("A_busy_after_start", 32'(busy), 32'd1);
        wait_done("A_done", 3000);
        chk("A_tests_run", 32'(tests_run), 32'd3);
        chk("A_detected", 32'(detected), 32'd0);
        chk("A_cov_met", 32'(cov_met), 32'd0);
        chk("A_inj_total", 32'(inj_total), 32'd12);
        chk("A_drst_pulses", 32'(rst_pulses), 32'd12);
        chk("A_drst_width", 32'(rst_max_w), 32'd1);
        chk("A_both_log_size", 32'(both_log.size()), 32'd12);
        chk("A_tv_log_size", 32'(tv_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < both_log.size(); i++) begin
            chk($sformatf("A_run_len_%0d", i), 32'(both_log[i]), 32'(exp_both[i]));
        end
        for (int i = 0; i < 12 && i < tv_log.size(); i++) begin
            chk($sformatf("A_tv_%0d", i), 32'(tv_log[i]), 32'(exp_tv[i / 4]));
        end
        repeat (5) @(negedge clk);
        chk("A_done_held", 32'(done), 32'd1);
        chk("A_idle_busy", 32'(busy), 32'd0);
        chk("A_idle_dut_reset", 32'(dut_reset), 32'd1);

        // B: faults 2 and 4 detected on the first test only; a stray start is ignored
        inj_delay  = 1;
        flag_set   = 8'b0001_0100;
        first_only = 1'b1;
        clear_mon();
        pulse_start();
        chk("B_done_cleared", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("B_done", 3000);
        chk("B_detected", 32'(detected), 32'd2);
        chk("B_tests_run", 32'(tests_run), 32'd3);
        chk("B_cov_met", 32'(cov_met), 32'd0);
        chk("B_inj_idx1", 32'(inj_per_idx[1]), 32'd3);
        chk("B_inj_idx2", 32'(inj_per_idx[2]), 32'd1);
        chk("B_inj_idx3", 32'(inj_per_idx[3]), 32'd3);
        chk("B_inj_idx4", 32'(inj_per_idx[4]), 32'd1);

        // C: only fault 3 detected each test -> below EF_MIN, never committed
        flag_set   = 8'b0000_1000;
        first_only = 1'b0;
        clear_mon();
        pulse_start();
        wait_done("C_done", 3000);
        chk("C_detected", 32'(detected), 32'd0);
        chk("C_tests_run", 32'(tests_run), 32'd3);
        chk("C_inj_idx3", 32'(inj_per_idx[3]), 32'd3);
        chk("C_inj_total", 32'(inj_total), 32'd12);

        // D: faults 1,2,3 detected on the first test -> 75% coverage, stop after one test
        flag_set   = 8'b0000_1110;
        first_only = 1'b1;
        clear_mon();
        pulse_start();
        wait_done("D_done", 3000);
        chk("D_detected", 32'(detected), 32'd3);
        chk("D_cov_met", 32'(cov_met), 32'd1);
        chk("D_tests_run", 32'(tests_run), 32'd1);
        chk("D_inj_total", 32'(inj_total), 32'd4);
        chk("AD_index_stable", 32'(idx_viol), 32'd0);

        // E: asynchronous reset during RUN, then restart from SEED
        flag_set = 8'h00;
        clear_mon();
        pulse_start();
        n = 0;
        while (!fault_ack && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("E_ack_seen", 32'(fault_ack), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("E_async_fault_req", 32'(fault_req), 32'd0);
        chk("E_async_dut_reset", 32'(dut_reset), 32'd1);
        chk("E_async_busy", 32'(busy), 32'd0);
        chk("E_async_tests_run", 32'(tests_run), 32'd0);
        @(negedge clk);
        chk("E_rst_cycle_dut_reset", 32'(dut_reset), 32'd1);
        chk("E_rst_cycle_fault_req", 32'(fault_req), 32'd0);
        reset_n = 1'b1;
        clear_mon();
        pulse_start();
        n = 0;
        while (!fault_req && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("E_restart_req", 32'(fault_req), 32'd1);
        chk("E_restart_tv", 32'(test_vector), 32'h03);
        chk("E_restart_tests_run", 32'(tests_run), 32'd1);
        chk("E_restart_index", 32'(fault_index), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
